// File: rtl/systolic_pkg.sv
// Shared constants and tile-layout helper for the systolic array front end.
package systolic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int MAC_WIDTH  = 2 * DEF_DATA_W + 8;

    // Bit offset of element (r,k) inside a flattened ROWS x DEPTH tile.
    function automatic int elem_off(input int k, input int r, input int rows, input int data_w);
        return (k * rows + r) * data_w;
    endfunction

endpackage

// File: rtl/skew_tile_bank.sv
// One tile store: whole-tile write, one element read per row at a per-row column index.
// Write lands on the clock edge; reads are combinational from stored state, no backpressure.
module skew_tile_bank
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = 8,
    parameter int DEPTH  = 8,
    parameter int KW     = 3
) (
    input  logic                         i_clk,
    input  logic                         i_wr_en,
    input  logic [DATA_W*ROWS*DEPTH-1:0] i_wr_tile,
    input  logic [ROWS*KW-1:0]           i_rd_k,
    output logic [ROWS*DATA_W-1:0]       o_rd_dat
);

    logic [DATA_W*ROWS*DEPTH-1:0] r_mem;

    // Contents are only meaningful while the owning bank is counted as occupied.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem <= i_wr_tile;
        end
    end

    always_comb begin
        o_rd_dat = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_rd_dat[r*DATA_W +: DATA_W] =
                r_mem[elem_off(int'(i_rd_k[r*KW +: KW]), r, ROWS, DATA_W) +: DATA_W];
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Double-buffered left-edge feeder: streams each tile as a skewed wavefront, row r delayed r beats.
// First beat the cycle after tile acceptance; outputs hold under out_ready=0, tile_ready drops when both banks are full.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + ROWS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [DATA_W*ROWS*DEPTH-1:0] i_tile_in,
    input  logic                         i_tile_valid,
    output logic                         o_tile_ready,
    output logic [DATA_W*ROWS-1:0]       o_row_out,
    output logic [ROWS-1:0]              o_lane_mask,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic                         o_out_first,
    output logic                         o_out_last,
    output logic                         o_busy
);

    localparam int T  = DEPTH + ROWS - 1;
    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    r_live;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_occ;
    logic [1:0]              w_occ_nxt;
    logic [CNT_W-1:0]        r_t;

    logic                    w_load;
    logic                    w_fire;
    logic                    w_last;
    logic                    w_release;
    logic [ROWS-1:0]         w_in_win;
    logic [ROWS*KW-1:0]      w_rd_k;
    logic [ROWS*DATA_W-1:0]  w_rd_dat0;
    logic [ROWS*DATA_W-1:0]  w_rd_dat1;

    // r_live keeps tile_ready low until the first edge after reset release.
    assign o_tile_ready = r_live && (r_occ != 2'd2);
    assign o_busy       = (r_occ != 2'd0);
    assign o_out_valid  = (r_state == ST_STREAM);
    assign w_last       = (r_t == CNT_W'(T - 1));
    assign o_out_first  = o_out_valid && (r_t == '0);
    assign o_out_last   = o_out_valid && w_last;

    assign w_load    = i_tile_valid && o_tile_ready;
    assign w_fire    = o_out_valid && i_out_ready;
    assign w_release = w_fire && w_last;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_load && !w_release) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_load && w_release) begin
            w_occ_nxt = r_occ - 2'd1;
        end

        // Deciding on next-occ lets a tile accepted at an edge stream in the very next cycle.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_occ_nxt != 2'd0) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_release && (w_occ_nxt == 2'd0)) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_t      <= '0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            if (w_load) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_release) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_t      <= '0;
            end else if (w_fire) begin
                r_t <= r_t + CNT_W'(1);
            end
        end
    end

    skew_tile_bank #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .DEPTH  (DEPTH),
        .KW     (KW)
    ) u_bank0 (
        .i_clk     (i_clk),
        .i_wr_en   (w_load && !r_wr_ptr),
        .i_wr_tile (i_tile_in),
        .i_rd_k    (w_rd_k),
        .o_rd_dat  (w_rd_dat0)
    );

    skew_tile_bank #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .DEPTH  (DEPTH),
        .KW     (KW)
    ) u_bank1 (
        .i_clk     (i_clk),
        .i_wr_en   (w_load && r_wr_ptr),
        .i_wr_tile (i_tile_in),
        .i_rd_k    (w_rd_k),
        .o_rd_dat  (w_rd_dat1)
    );

    // Lane r shows column t-r while that index lies inside the tile, zero padding otherwise.
    always_comb begin
        int d;
        w_in_win = '0;
        w_rd_k   = '0;
        for (int r = 0; r < ROWS; r++) begin
            d = int'(r_t) - r;
            w_in_win[r] = (d >= 0) && (d < DEPTH);
            if (w_in_win[r]) begin
                w_rd_k[r*KW +: KW] = KW'(d);
            end
        end
    end

    always_comb begin
        o_row_out   = '0;
        o_lane_mask = o_out_valid ? w_in_win : '0;
        for (int r = 0; r < ROWS; r++) begin
            if (o_out_valid && w_in_win[r]) begin
                o_row_out[r*DATA_W +: DATA_W] = r_rd_ptr ? w_rd_dat1[r*DATA_W +: DATA_W]
                                                         : w_rd_dat0[r*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench: ROWS=4/DEPTH=3 feeder plus a ROWS=1/DEPTH=1 degenerate instance.
module tb_systolic_skew_feeder;

    typedef struct packed {
        logic [31:0] row;
        logic [3:0]  mask;
        logic        first;
        logic        last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4x3 instance
    logic [95:0] a_tile_in    = '0;
    logic        a_tile_valid = 1'b0;
    logic        a_tile_ready;
    logic [31:0] a_row_out;
    logic [3:0]  a_lane_mask;
    logic        a_out_valid;
    logic        a_out_ready  = 1'b1;
    logic        a_out_first;
    logic        a_out_last;
    logic        a_busy;

    // 1x1 instance
    logic [7:0]  b_tile_in    = '0;
    logic        b_tile_valid = 1'b0;
    logic        b_tile_ready;
    logic [7:0]  b_row_out;
    logic [0:0]  b_lane_mask;
    logic        b_out_valid;
    logic        b_out_ready  = 1'b1;
    logic        b_out_first;
    logic        b_out_last;
    logic        b_busy;

    systolic_skew_feeder #(.DATA_W(8), .ROWS(4), .DEPTH(3)) dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tile_in    (a_tile_in),
        .i_tile_valid (a_tile_valid),
        .o_tile_ready (a_tile_ready),
        .o_row_out    (a_row_out),
        .o_lane_mask  (a_lane_mask),
        .o_out_valid  (a_out_valid),
        .i_out_ready  (a_out_ready),
        .o_out_first  (a_out_first),
        .o_out_last   (a_out_last),
        .o_busy       (a_busy)
    );

    systolic_skew_feeder #(.DATA_W(8), .ROWS(1), .DEPTH(1)) dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tile_in    (b_tile_in),
        .i_tile_valid (b_tile_valid),
        .o_tile_ready (b_tile_ready),
        .o_row_out    (b_row_out),
        .o_lane_mask  (b_lane_mask),
        .o_out_valid  (b_out_valid),
        .i_out_ready  (b_out_ready),
        .o_out_first  (b_out_first),
        .o_out_last   (b_out_last),
        .o_busy       (b_busy)
    );

    // Hand-computed wavefront for A[r][k] = 16r+k+1, lanes listed 0..3.
    int ref_lane [6][4] = '{'{1, 0, 0, 0}, '{2, 17, 0, 0}, '{3, 18, 33, 0},
                            '{0, 19, 34, 49}, '{0, 0, 35, 50}, '{0, 0, 0, 51}};
    logic [3:0] ref_mask [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

    beat_t exp_q[$];
    beat_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] build_tile(input int off);
        logic [95:0] t;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 3; k++)
                t[(k*4 + r)*8 +: 8] = 8'(off + 16*r + k + 1);
        return t;
    endfunction

    task automatic push_exp(input int off);
        for (int t = 0; t < 6; t++) begin
            beat_t b;
            b = '0;
            for (int r = 0; r < 4; r++)
                if (ref_mask[t][r]) b.row[r*8 +: 8] = 8'(ref_lane[t][r] + off);
            b.mask  = ref_mask[t];
            b.first = (t == 0);
            b.last  = (t == 5);
            exp_q.push_back(b);
        end
    endtask

    // Offers a tile and returns #1 after the accepting edge.
    task automatic send_a(input int off);
        bit done;
        done = 1'b0;
        a_tile_in    = build_tile(off);
        a_tile_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (a_tile_ready) begin
                push_exp(off);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        a_tile_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tile_ready never seen, required 1");
        end
    endtask

    // Returns at the posedge on which every expected beat has been consumed.
    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got row 0x%0h, required no beat", a_row_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("row_out",   64'(a_row_out),   64'(mon_e.row));
                chk("lane_mask", 64'(a_lane_mask), 64'(mon_e.mask));
                chk("out_first", 64'(a_out_first), 64'(mon_e.first));
                chk("out_last",  64'(a_out_last),  64'(mon_e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #3;
        chk("rst_tile_ready", 64'(a_tile_ready), 64'd0);
        chk("rst_out_valid",  64'(a_out_valid),  64'd0);
        chk("rst_first_last", 64'({a_out_first, a_out_last}), 64'd0);
        chk("rst_busy",       64'(a_busy),       64'd0);
        chk("rst_row_mask",   64'({a_row_out, a_lane_mask}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(a_tile_ready), 64'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", 64'(a_tile_ready), 64'd1);

        // Single tile with first-beat latency
        send_a(0);
        chk("latency_valid", 64'(a_out_valid), 64'd1);
        chk("latency_first", 64'(a_out_first), 64'd1);
        wait_drain();
        #1;
        chk("single_idle_valid", 64'(a_out_valid), 64'd0);
        chk("single_idle_busy",  64'(a_busy),      64'd0);

        // Back-to-back tiles: contiguous 12 beats
        repeat (2) @(posedge clk);
        #1;
        send_a(0);
        send_a(100);
        chk("b2b_ready_full", 64'(a_tile_ready), 64'd0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("b2b_contiguous", 64'(a_out_valid), 64'd1);
            if (i < 5)  chk("b2b_ready_low",  64'(a_tile_ready), 64'd0);
            if (i == 5) chk("b2b_ready_back", 64'(a_tile_ready), 64'd1);
        end
        @(negedge clk);
        chk("b2b_end_valid", 64'(a_out_valid), 64'd0);
        wait_drain();

        // Backpressure at t=2
        repeat (2) @(posedge clk);
        #1;
        send_a(0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(a_out_valid), 64'd1);
            chk("stall_row",   64'(a_row_out),   64'h0021_1203);
            chk("stall_mask",  64'(a_lane_mask), 64'b0111);
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        wait_drain();

        // Load while full
        repeat (2) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        send_a(0);
        send_a(100);
        a_tile_in    = build_tile(200);
        a_tile_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_ready", 64'(a_tile_ready), 64'd0);
            chk("full_busy",  64'(a_busy),       64'd1);
        end
        @(posedge clk);
        #1;
        a_tile_valid = 1'b0;
        a_out_ready  = 1'b1;
        wait_drain();

        // Reset mid-stream at t=3
        repeat (2) @(posedge clk);
        #1;
        send_a(0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid",    64'(a_out_valid),  64'd0);
        chk("mid_rst_row_mask", 64'({a_row_out, a_lane_mask}), 64'd0);
        chk("mid_rst_flags",    64'({a_out_first, a_out_last, a_busy, a_tile_ready}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_a(100);
        wait_drain();

        // Degenerate 1x1 instance
        @(posedge clk);
        #1;
        b_tile_in    = 8'd7;
        b_tile_valid = 1'b1;
        @(negedge clk);
        chk("deg_ready", 64'(b_tile_ready), 64'd1);
        @(posedge clk);
        #1;
        b_tile_valid = 1'b0;
        chk("deg_valid", 64'(b_out_valid), 64'd1);
        chk("deg_lane",  64'(b_row_out),   64'd7);
        chk("deg_mask",  64'(b_lane_mask), 64'd1);
        chk("deg_first_last", 64'({b_out_first, b_out_last}), 64'b11);
        @(posedge clk);
        #1;
        chk("deg_after_valid", 64'(b_out_valid), 64'd0);
        chk("deg_after_busy",  64'(b_busy),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
